// File: rtl/nanoxera_boot_loader_pkg.sv
// Shared constants and state encodings for the NanoXERA serial boot loader.
// RAM geometry here must stay in step with the CPU top level.
package nanoxera_boot_loader_pkg;

    localparam int unsigned RAM_ADDR_W        = 8;
    localparam int unsigned RAM_DEPTH         = 2 ** RAM_ADDR_W;
    localparam int unsigned RAM_WIDTH         = 8;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM,
        DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/nanoxera_boot_loader_if.sv
// RAM write port shared between the boot loader (master) and the RAM (slave).
interface nanoxera_boot_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;

    modport master (output mem_addr, output mem_wdata, output mem_we);
    modport slave  (input  mem_addr, input  mem_wdata, input  mem_we);
endinterface

// File: rtl/nanoxera_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// rx_valid / rx_ferr pulses.
module nanoxera_uart_rx
    import nanoxera_boot_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Only a genuine high->low edge opens a frame, so a line held low after a
    // framing error cannot retrigger until it has returned to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/nanoxera_boot_loader.sv
// Serial boot loader: receives SYNC,LEN,data...,SUM over UART, writes the
// payload into RAM, and releases the CPU from reset once the checksum matches.
module nanoxera_boot_loader
    import nanoxera_boot_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned ADDR_W       = RAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    nanoxera_boot_loader_if.master mem,
    output logic                   cpu_rst_n,
    output logic                   done,
    output logic                   err
);
    localparam int unsigned RW = ADDR_W + 1;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    loader_state_t     state;
    logic [RW-1:0]     remaining;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        sum;

    nanoxera_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_SYNC;
            remaining     <= '0;
            addr_cnt      <= '0;
            sum           <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_we    <= 1'b0;
            cpu_rst_n     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            mem.mem_we <= 1'b0;
            if (rx_ferr) begin
                if (state != DONE) begin
                    err       <= 1'b1;
                    cpu_rst_n <= 1'b0;
                    state     <= WAIT_SYNC;
                end
            end else if (rx_valid) begin
                case (state)
                    WAIT_SYNC, DONE: begin
                        if (rx_data == SYNC_BYTE) begin
                            err       <= 1'b0;
                            done      <= 1'b0;
                            cpu_rst_n <= 1'b0;
                            state     <= GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        remaining <= (rx_data == 8'd0) ? RW'(2 ** ADDR_W) : RW'(rx_data);
                        addr_cnt  <= '0;
                        sum       <= '0;
                        state     <= GET_DATA;
                    end
                    GET_DATA: begin
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= addr_cnt;
                        mem.mem_wdata <= rx_data;
                        // Wraps to 0 only after the 256th byte of a full load.
                        addr_cnt      <= addr_cnt + ADDR_W'(1);
                        sum           <= sum + rx_data;
                        remaining     <= remaining - RW'(1);
                        if (remaining == RW'(1)) state <= GET_SUM;
                    end
                    GET_SUM: begin
                        if (rx_data == sum) begin
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                            state     <= DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= WAIT_SYNC;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nanoxera_boot_loader.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a monitor pops and
// compares on every mem_we pulse; status flags are checked after each packet.
module tb_nanoxera_boot_loader;
    localparam int unsigned CPB = 16;
    localparam int unsigned CLK_P = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic cpu_rst_n, done, err;

    nanoxera_boot_loader_if #(.ADDR_W(8)) mem ();

    nanoxera_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .ADDR_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .mem      (mem.master),
        .cpu_rst_n(cpu_rst_n),
        .done     (done),
        .err      (err)
    );

    always #(CLK_P / 2) clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  ram [256];

    always @(negedge clk) begin
        if (rst_n && mem.mem_we) begin
            logic [15:0] got;
            got = {mem.mem_addr, mem.mem_wdata};
            ram[mem.mem_addr] = mem.mem_wdata;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%02h data=%02h, required none", got[15:8], got[7:0]);
            end else begin
                logic [15:0] want;
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             got[15:8], got[7:0], want[15:8], want[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        #(CPB * CLK_P);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(CPB * CLK_P);
        end
        rx = stop;
        #(CPB * CLK_P);
        rx = 1'b1;
        #(2 * CLK_P);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic c);
        #(4 * CLK_P);
        check({name, "_done"}, 32'(done), 32'(d));
        check({name, "_err"}, 32'(err), 32'(e));
        check({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
    endtask

    task automatic check_drained(input string name);
        #(4 * CLK_P);
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic packet1;
        send_byte(8'hA5); send_byte(8'h03);
        expect_wr(8'h00, 8'h11); send_byte(8'h11);
        expect_wr(8'h01, 8'h22); send_byte(8'h22);
        expect_wr(8'h02, 8'h33); send_byte(8'h33);
        send_byte(8'h66);
    endtask

    initial begin
        #(3 * CLK_P + 2);
        check("rst_addr", 32'(mem.mem_addr), 32'h0);
        check("rst_wdata", 32'(mem.mem_wdata), 32'h0);
        check("rst_we", 32'(mem.mem_we), 32'h0);
        check("rst_flags", {29'd0, cpu_rst_n, done, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #(5 * CLK_P);

        // 1: basic three-byte load
        packet1();
        check_status("c1", 1'b1, 1'b0, 1'b1);
        check_drained("c1");
        check("c1_ram2", 32'(ram[2]), 32'h33);

        // 2: bad checksum, then good reload
        send_byte(8'hA5); send_byte(8'h02);
        expect_wr(8'h00, 8'h01); send_byte(8'h01);
        expect_wr(8'h01, 8'h02); send_byte(8'h02);
        send_byte(8'h00);
        check_status("c2a", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5); send_byte(8'h01);
        expect_wr(8'h00, 8'h7F); send_byte(8'h7F);
        send_byte(8'h7F);
        check_status("c2b", 1'b1, 1'b0, 1'b1);
        check_drained("c2");

        // 3: leading junk ignored (including while DONE)
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check_status("c3_junk", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h01);
        expect_wr(8'h00, 8'hC3); send_byte(8'hC3);
        send_byte(8'hC3);
        check_status("c3", 1'b1, 1'b0, 1'b1);
        check_drained("c3");

        // 4: LEN=0 means full 256-byte load
        send_byte(8'hA5); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            expect_wr(8'(i), 8'(i));
            send_byte(8'(i));
        end
        send_byte(8'h80);
        check_status("c4", 1'b1, 1'b0, 1'b1);
        check_drained("c4");
        check("c4_ram_ff", 32'(ram[255]), 32'hFF);

        // 5: framing error mid-packet, then an idle-line glitch
        send_byte(8'hA5); send_byte(8'h02);
        expect_wr(8'h00, 8'h10); send_byte(8'h10);
        send_byte(8'h44, 1'b0);
        check_status("c5_ferr", 1'b0, 1'b1, 1'b0);
        rx = 1'b0;
        #(6 * CLK_P);
        rx = 1'b1;
        #(3 * CPB * CLK_P);
        check_status("c5_glitch", 1'b0, 1'b1, 1'b0);
        check_drained("c5");

        // 6: async reset mid GET_DATA, then a clean reload
        send_byte(8'hA5); send_byte(8'h03);
        expect_wr(8'h00, 8'h11); send_byte(8'h11);
        check_drained("c6_pre");
        #3;
        rst_n = 1'b0;
        #1;
        check("c6_rst_wdata", 32'(mem.mem_wdata), 32'h0);
        check("c6_rst_flags", {29'd0, cpu_rst_n, done, err, mem.mem_we}, 32'h0);
        #(3 * CLK_P);
        @(negedge clk);
        rst_n = 1'b1;
        #(5 * CLK_P);
        packet1();
        check_status("c6", 1'b1, 1'b0, 1'b1);
        check_drained("c6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
